// File: rtl/radix2_divider.sv
// Iterative restoring divider: one quotient bit per cycle, RISC-V DIV/DIVU/REM/REMU results.
// Shares the start/done handshake and branch_mispredict flush of the wallace multiplier.
module radix2_divider #(
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     branch_mispredict,
  input  logic                     start,
  input  logic [1:0]               div_type,
  input  logic [OPERAND_WIDTH-1:0] a,
  input  logic [OPERAND_WIDTH-1:0] b,
  output logic [OPERAND_WIDTH-1:0] quotient,
  output logic [OPERAND_WIDTH-1:0] remainder,
  output logic                     busy,
  output logic                     done
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETUP, ITERATE, FIXUP, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_r, b_r, dvd, b_mag;
  logic [1:0]     type_r;
  logic           neg_q, neg_r;
  logic [W:0]     rem;
  logic [CW-1:0]  cnt;

  logic           is_signed, div_zero, sgn_ovf, last_iter;
  logic [W:0]     rem_shift, trial;
  logic           ge;

  function automatic logic [W-1:0] neg2c(input logic [W-1:0] x);
    return (~x) + W'(1);
  endfunction

  // -MIN wraps to MIN, which is the right unsigned magnitude.
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? neg2c(x) : x;
  endfunction

  assign is_signed = (type_r == 2'b01);
  assign div_zero  = (b_r == '0);
  assign sgn_ovf   = is_signed && (a_r == MIN_VAL) && (b_r == '1);
  assign last_iter = (cnt == CW'(W - 1));

  // Restoring step; a set rem[W] would already exceed any divisor.
  always_comb begin
    rem_shift = {rem[W-1:0], dvd[W-1]};
    trial     = rem_shift - {1'b0, b_mag};
    ge        = rem[W] | (rem_shift >= {1'b0, b_mag});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:    if (start && !branch_mispredict) state_nxt = SETUP;
      SETUP:   state_nxt = (div_zero || sgn_ovf) ? DONE : ITERATE;
      ITERATE: if (last_iter) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        done      = !branch_mispredict;
      end
      default: state_nxt = IDLE;
    endcase
    if (branch_mispredict) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      type_r    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvd       <= '0;
      b_mag     <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!branch_mispredict) begin
      case (state)
        IDLE: if (start) begin
          a_r    <= a;
          b_r    <= b;
          type_r <= div_type;
        end
        SETUP: begin
          neg_q <= is_signed & (a_r[W-1] ^ b_r[W-1]);
          neg_r <= is_signed & a_r[W-1];
          dvd   <= abs_val(a_r, is_signed);
          b_mag <= abs_val(b_r, is_signed);
          rem   <= '0;
          cnt   <= '0;
          if (div_zero) begin
            quotient  <= '1;
            remainder <= a_r;
          end else if (sgn_ovf) begin
            quotient  <= MIN_VAL;
            remainder <= '0;
          end
        end
        ITERATE: begin
          rem <= ge ? trial : rem_shift;
          dvd <= {dvd[W-2:0], ge};
          cnt <= cnt + CW'(1);
        end
        FIXUP: begin
          quotient  <= neg_q ? neg2c(dvd) : dvd;
          remainder <= neg_r ? neg2c(rem[W-1:0]) : rem[W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
